// File: rtl/axis_pkg.sv
// Shared types and byte-count helpers for the AXI-Stream header inserter.
// Masks are computed at the widest supported stream (64 bytes); callers truncate.
package axis_pkg;

    localparam int MAX_BYTES = 64;

    typedef logic [MAX_BYTES-1:0] kmask_t;
    typedef logic [7:0]           bcnt_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    function automatic bcnt_t popcount(input kmask_t v);
        bcnt_t c;
        c = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            c = c + bcnt_t'(v[i]);
        end
        return c;
    endfunction

    function automatic kmask_t low_mask(input bcnt_t n);
        kmask_t m;
        m = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (i < int'(n)) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Top n bits of a width-bit keep field (the first n bytes on the wire).
    function automatic kmask_t top_mask(input bcnt_t n, input bcnt_t width);
        kmask_t m;
        m = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (i < int'(width) && i + int'(n) >= int'(width)) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/axis_byte_merge.sv
// Combinational byte merge: prepends the residual bytes to a beat, masks dead lanes,
// and extracts the low bytes that carry over into the next beat.
module axis_byte_merge
    import axis_pkg::*;
#(
    parameter int DATA_WD = 32
) (
    input  logic [DATA_WD-1:0]   residual,
    input  logic [DATA_WD-1:0]   data,
    input  logic [7:0]           shift,
    input  logic [DATA_WD/8-1:0] keep,
    output logic [DATA_WD-1:0]   merged,
    output logic [DATA_WD-1:0]   tail
);

    localparam int BYTE_WD = DATA_WD / 8;

    logic [BYTE_WD-1:0] low_keep;
    logic [DATA_WD-1:0] lane_mask;
    logic [DATA_WD-1:0] low_lanes;

    always_comb begin
        low_keep  = BYTE_WD'(low_mask(shift));
        lane_mask = '0;
        low_lanes = '0;
        for (int i = 0; i < BYTE_WD; i++) begin
            lane_mask[8*i +: 8] = {8{keep[i]}};
            low_lanes[8*i +: 8] = {8{low_keep[i]}};
        end
        // Residual sits in the low shift bytes; shifting the pair right leaves it on top.
        merged = DATA_WD'({residual, data} >> {shift, 3'b000}) & lane_mask;
        tail   = data & low_lanes;
    end

endmodule

// File: rtl/axis_hdr_insert_param.sv
// Inserts a variable-length header (0..BYTE_WD bytes) in front of each payload packet,
// realigning the payload bytes and emitting a trailing flush beat when the tail overflows.
module axis_hdr_insert_param
    import axis_pkg::*;
#(
    parameter int DATA_WD = 32,
    parameter int BYTE_WD = DATA_WD / 8,
    parameter int CNT_WD  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_in,
    input  logic [DATA_WD-1:0] data_in,
    input  logic [BYTE_WD-1:0] keep_in,
    input  logic               last_in,
    output logic               ready_in,
    input  logic               valid_insert,
    input  logic [DATA_WD-1:0] header_insert,
    input  logic [BYTE_WD-1:0] keep_insert,
    output logic               ready_insert,
    output logic               valid_out,
    output logic [DATA_WD-1:0] data_out,
    output logic [BYTE_WD-1:0] keep_out,
    output logic               last_out,
    input  logic               ready_out,
    output logic [CNT_WD-1:0]  pkt_cnt
);

    localparam bcnt_t BYTES = bcnt_t'(BYTE_WD);

    // Handshake rule on all three ports: a beat transfers on a rising clk edge where
    // valid and ready are both high; valid never waits on ready.
    state_t             state;
    logic [DATA_WD-1:0] residual;
    bcnt_t              hdr_bytes;
    bcnt_t              flush_bytes;

    bcnt_t              hdr_cnt;
    bcnt_t              in_cnt;
    bcnt_t              total;
    bcnt_t              shift;
    logic               fits;
    logic               out_free;
    logic               in_fire;
    logic               hdr_fire;
    logic [DATA_WD-1:0] merge_data;
    logic [BYTE_WD-1:0] out_keep;
    logic               out_last;
    logic [DATA_WD-1:0] merged;
    logic [DATA_WD-1:0] tail;

    assign out_free = !valid_out || ready_out;
    assign ready_in = (state == STREAM) && out_free;
    assign in_fire  = valid_in && ready_in;
    assign hdr_fire = valid_insert && ready_insert;

    always_comb begin
        hdr_cnt    = popcount(kmask_t'(keep_insert));
        in_cnt     = popcount(kmask_t'(keep_in));
        total      = hdr_bytes + in_cnt;
        fits       = total <= BYTES;
        shift      = hdr_bytes;
        merge_data = data_in;
        out_keep   = '1;
        out_last   = 1'b0;
        case (state)
            IDLE: begin
                // Reuse the merge tail path to capture the low H header bytes.
                shift      = hdr_cnt;
                merge_data = header_insert;
            end
            FLUSH: begin
                merge_data = '0;
                out_keep   = BYTE_WD'(top_mask(flush_bytes, BYTES));
                out_last   = 1'b1;
            end
            default: begin
                if (last_in && fits) begin
                    out_keep = BYTE_WD'(top_mask(total, BYTES));
                    out_last = 1'b1;
                end
            end
        endcase
    end

    axis_byte_merge #(
        .DATA_WD(DATA_WD)
    ) u_merge (
        .residual(residual),
        .data    (merge_data),
        .shift   (shift),
        .keep    (out_keep),
        .merged  (merged),
        .tail    (tail)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ready_insert <= 1'b0;
            valid_out    <= 1'b0;
            last_out     <= 1'b0;
            data_out     <= '0;
            keep_out     <= '0;
            pkt_cnt      <= '0;
            residual     <= '0;
            hdr_bytes    <= '0;
            flush_bytes  <= '0;
        end else begin
            if (valid_out && ready_out) begin
                valid_out <= 1'b0;
                if (last_out) pkt_cnt <= pkt_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    ready_insert <= 1'b1;
                    if (hdr_fire) begin
                        residual     <= tail;
                        hdr_bytes    <= hdr_cnt;
                        ready_insert <= 1'b0;
                        state        <= STREAM;
                    end
                end
                STREAM: begin
                    if (in_fire) begin
                        valid_out <= 1'b1;
                        data_out  <= merged;
                        keep_out  <= out_keep;
                        last_out  <= out_last;
                        residual  <= tail;
                        if (last_in) begin
                            if (fits) begin
                                state        <= IDLE;
                                ready_insert <= 1'b1;
                            end else begin
                                flush_bytes <= total - BYTES;
                                state       <= FLUSH;
                            end
                        end
                    end
                end
                FLUSH: begin
                    if (out_free) begin
                        valid_out    <= 1'b1;
                        data_out     <= merged;
                        keep_out     <= out_keep;
                        last_out     <= 1'b1;
                        state        <= IDLE;
                        ready_insert <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_hdr_insert_param.sv
// Bench for axis_hdr_insert_param at DATA_WD=32: directed vector table, stall and reset
// sequences, and random packets checked against a byte-queue reference model.
module tb_axis_hdr_insert_param;

    localparam int DW = 32;
    localparam int BW = 4;
    localparam int CW = 16;
    localparam int EW = DW + BW + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid_in = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [BW-1:0] keep_in = '0;
    logic          last_in = 1'b0;
    logic          ready_in;
    logic          valid_insert = 1'b0;
    logic [DW-1:0] header_insert = '0;
    logic [BW-1:0] keep_insert = '0;
    logic          ready_insert;
    logic          valid_out;
    logic [DW-1:0] data_out;
    logic [BW-1:0] keep_out;
    logic          last_out;
    logic          ready_out = 1'b1;
    logic [CW-1:0] pkt_cnt;

    always #5 clk = ~clk;

    axis_hdr_insert_param #(
        .DATA_WD(DW),
        .BYTE_WD(BW),
        .CNT_WD (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_in     (valid_in),
        .data_in      (data_in),
        .keep_in      (keep_in),
        .last_in      (last_in),
        .ready_in     (ready_in),
        .valid_insert (valid_insert),
        .header_insert(header_insert),
        .keep_insert  (keep_insert),
        .ready_insert (ready_insert),
        .valid_out    (valid_out),
        .data_out     (data_out),
        .keep_out     (keep_out),
        .last_out     (last_out),
        .ready_out    (ready_out),
        .pkt_cnt      (pkt_cnt)
    );

    typedef struct {
        logic [DW-1:0] hdr;
        logic [BW-1:0] hkeep;
        int            nb;
        logic [DW-1:0] d[2];
        logic [BW-1:0] lkeep;
        int            no;
        logic [DW-1:0] od[3];
        logic [BW-1:0] ok[3];
        logic          ol[3];
    } vec_t;

    vec_t          vecs[7];
    int            checks = 0;
    int            errors = 0;
    logic [EW-1:0] exp_q[$];
    logic          rnd_bp = 1'b0;
    logic          ready_force = 1'b1;
    int            exp_pkts = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=handshake", name);
    endtask

    task automatic drive_header(input logic [DW-1:0] h, input logic [BW-1:0] k, input int gap);
        int n;
        n = 0;
        repeat (gap) @(posedge clk);
        if (gap > 0) #1;
        header_insert = h;
        keep_insert   = k;
        valid_insert  = 1'b1;
        forever begin
            @(negedge clk);
            if (ready_insert || n > 200) break;
            n++;
        end
        if (!ready_insert) timeout("header_wait");
        @(posedge clk);
        #1;
        valid_insert = 1'b0;
    endtask

    task automatic drive_beat(input logic [DW-1:0] d, input logic [BW-1:0] k, input logic l,
                              input int gap);
        int n;
        n = 0;
        repeat (gap) @(posedge clk);
        if (gap > 0) #1;
        data_in  = d;
        keep_in  = k;
        last_in  = l;
        valid_in = 1'b1;
        forever begin
            @(negedge clk);
            if (ready_in || n > 200) break;
            n++;
        end
        if (!ready_in) timeout("beat_wait");
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        last_in  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) timeout("drain");
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int v);
        for (int i = 0; i < vecs[v].no; i++) begin
            exp_q.push_back({vecs[v].od[i], vecs[v].ok[i], vecs[v].ol[i]});
        end
        drive_header(vecs[v].hdr, vecs[v].hkeep, 0);
        for (int b = 0; b < vecs[v].nb; b++) begin
            if (b == vecs[v].nb - 1) drive_beat(vecs[v].d[b], vecs[v].lkeep, 1'b1, 0);
            else                     drive_beat(vecs[v].d[b], 4'hF, 1'b0, 0);
        end
        drain();
        exp_pkts++;
        check($sformatf("pkt_cnt_vec%0d", v), 64'(pkt_cnt), 64'(exp_pkts));
    endtask

    initial begin
        logic [DW-1:0] pd[4];
        logic [DW-1:0] hdr;
        logic [DW-1:0] od;
        logic [BW-1:0] ok;
        logic [BW-1:0] hk;
        logic [BW-1:0] lk;
        logic [7:0]    bq[$];
        int            hlen;
        int            nb;
        int            nl;
        int            cnt;
        int            n;

        vecs[0] = '{32'hAABBCCDD, 4'hF, 2, '{32'h11223344, 32'h55667788}, 4'hF,
                    3, '{32'hAABBCCDD, 32'h11223344, 32'h55667788}, '{4'hF, 4'hF, 4'hF}, '{0, 0, 1}};
        vecs[1] = '{32'h0000EEFF, 4'h3, 2, '{32'h11223344, 32'h55667788}, 4'hC,
                    2, '{32'hEEFF1122, 32'h33445566, 32'h0}, '{4'hF, 4'hF, 4'h0}, '{0, 1, 0}};
        vecs[2] = '{32'h00A1B2C3, 4'h7, 1, '{32'h11223344, 32'h0}, 4'hE,
                    2, '{32'hA1B2C311, 32'h22330000, 32'h0}, '{4'hF, 4'hC, 4'h0}, '{0, 1, 0}};
        vecs[3] = '{32'h00000000, 4'h0, 1, '{32'hDEADBEEF, 32'h0}, 4'h8,
                    1, '{32'hDE000000, 32'h0, 32'h0}, '{4'h8, 4'h0, 4'h0}, '{1, 0, 0}};
        vecs[4] = '{32'h000000AB, 4'h1, 2, '{32'h11223344, 32'h55667788}, 4'hE,
                    2, '{32'hAB112233, 32'h44556677, 32'h0}, '{4'hF, 4'hF, 4'h0}, '{0, 1, 0}};
        vecs[5] = '{32'h01020304, 4'hF, 1, '{32'hCAFEBABE, 32'h0}, 4'h8,
                    2, '{32'h01020304, 32'hCA000000, 32'h0}, '{4'hF, 4'h8, 4'h0}, '{0, 1, 0}};
        vecs[6] = '{32'h00001234, 4'h3, 1, '{32'h89ABCDEF, 32'h0}, 4'hF,
                    2, '{32'h123489AB, 32'hCDEF0000, 32'h0}, '{4'hF, 4'hC, 4'h0}, '{0, 1, 0}};

        // Output monitor: every handshaken beat must match the head of the expected queue.
        fork
            forever begin
                @(negedge clk);
                if (rst_n && valid_out && ready_out) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat actual=%h required=none",
                                 {data_out, keep_out, last_out});
                    end else begin
                        od = exp_q[0][EW-1 -: DW];
                        if ({data_out, keep_out, last_out} !== exp_q[0]) begin
                            errors++;
                            $display("FAIL out_beat actual=%h/%h/%b required=%h/%h/%b",
                                     data_out, keep_out, last_out, od,
                                     exp_q[0][BW:1], exp_q[0][0]);
                        end
                        void'(exp_q.pop_front());
                    end
                end
            end
            forever begin
                @(posedge clk);
                #2;
                ready_out = rnd_bp ? ($urandom_range(0, 3) != 0) : ready_force;
            end
        join_none

        // Power-on reset.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs",
              64'({valid_out, data_out, keep_out, last_out, ready_in, ready_insert, pkt_cnt}), 64'd0);
        #2;
        rst_n = 1'b1;
        #1;
        check("ready_insert_before_edge", 64'(ready_insert), 64'd0);
        @(posedge clk);
        #1;
        check("ready_insert_after_edge", 64'(ready_insert), 64'd1);

        for (int v = 0; v < 7; v++) run_vec(v);

        // Header-free pass-through: output one cycle after the input handshake.
        exp_q.push_back({32'hDE000000, 4'h8, 1'b1});
        drive_header(32'h12345678, 4'h0, 0);
        drive_beat(32'hDEADBEEF, 4'h8, 1'b1, 0);
        check("latency_one_cycle", 64'({valid_out, data_out, keep_out, last_out}),
              64'({1'b1, 32'hDE000000, 4'h8, 1'b1}));
        drain();
        exp_pkts++;
        check("pkt_cnt_latency", 64'(pkt_cnt), 64'(exp_pkts));

        // Output stall mid-packet: held beat stays put, no new input accepted.
        ready_force = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back({32'hEEFF1122, 4'hF, 1'b0});
        exp_q.push_back({32'h33445566, 4'hF, 1'b1});
        fork
            begin
                drive_header(32'h0000EEFF, 4'h3, 0);
                drive_beat(32'h11223344, 4'hF, 1'b0, 0);
                drive_beat(32'h55667788, 4'hC, 1'b1, 0);
            end
            begin
                n = 0;
                forever begin
                    @(negedge clk);
                    if (valid_out || n > 200) break;
                    n++;
                end
                if (!valid_out) timeout("stall_wait");
                for (int i = 0; i < 3; i++) begin
                    check($sformatf("stall_hold_%0d", i), 64'({valid_out, data_out, ready_in}),
                          64'({1'b1, 32'hEEFF1122, 1'b0}));
                    if (i < 2) @(negedge clk);
                end
                ready_force = 1'b1;
            end
        join
        drain();
        exp_pkts++;
        check("pkt_cnt_stall", 64'(pkt_cnt), 64'(exp_pkts));

        // Reset in the middle of a packet: nothing of it may reach the output.
        drive_header(32'hAABBCCDD, 4'hF, 0);
        drive_beat(32'h11223344, 4'hF, 1'b0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midpkt_reset_outputs",
              64'({valid_out, data_out, keep_out, last_out, ready_in, ready_insert, pkt_cnt}), 64'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        check("midpkt_ready_insert_low", 64'(ready_insert), 64'd0);
        @(posedge clk);
        #1;
        check("midpkt_ready_insert_high", 64'(ready_insert), 64'd1);
        exp_pkts = 0;
        run_vec(0);

        // Random packets with random backpressure and input gaps.
        rnd_bp = 1'b1;
        for (int p = 0; p < 80; p++) begin
            hlen = $urandom_range(0, 4);
            nb   = $urandom_range(1, 4);
            nl   = $urandom_range(1, 4);
            hdr  = $urandom;
            hk   = 4'((1 << hlen) - 1);
            lk   = 4'(4'hF << (4 - nl));
            for (int j = 0; j < 4; j++) pd[j] = $urandom;
            bq.delete();
            for (int b = hlen - 1; b >= 0; b--) bq.push_back(hdr[8*b +: 8]);
            for (int j = 0; j < nb; j++) begin
                cnt = (j == nb - 1) ? nl : 4;
                for (int b = 3; b >= 4 - cnt; b--) bq.push_back(pd[j][8*b +: 8]);
            end
            while (bq.size() > 0) begin
                od = '0;
                ok = '0;
                for (int j = 0; j < 4 && bq.size() > 0; j++) begin
                    od[8*(3-j) +: 8] = bq.pop_front();
                    ok[3-j] = 1'b1;
                end
                exp_q.push_back({od, ok, bq.size() == 0});
            end
            drive_header(hdr, hk, $urandom_range(0, 2));
            for (int j = 0; j < nb; j++) begin
                if (j == nb - 1) drive_beat(pd[j], lk, 1'b1, $urandom_range(0, 1));
                else             drive_beat(pd[j], 4'hF, 1'b0, $urandom_range(0, 1));
            end
            exp_pkts++;
        end
        drain();
        rnd_bp = 1'b0;
        check("pkt_cnt_random", 64'(pkt_cnt), 64'(exp_pkts));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
